// File: rtl/uart_rx_ctrl_if.sv
// Avalon-MM slave bus plus level interrupt for the UART receive controller.
interface uart_rx_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures bytes from the receiver core into a FIFO and exposes
// DATA/STATUS/CTRL/DIVISOR registers on an Avalon-MM slave with a level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned Depth    = 8,
    parameter logic [15:0] DivReset = 16'd434
) (
    input  logic           clk_i,
    input  logic           reset_i,
    uart_rx_ctrl_if.slave  bus,
    input  logic [7:0]     rx_data_i,
    input  logic           rx_done_i,
    output logic           rx_enable_o,
    output logic [15:0]    baud_div_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrDiv    = 2'd3;

    logic [7:0]      mem [Depth];
    logic            rx_done_q;
    logic            push_q, push_req;
    logic [7:0]      push_byte_q;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overrun_q, overrun_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [15:0]     div_q, div_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            irq_q, irq_d;
    logic            not_empty, full, rd_ok, pop, push;
    logic [7:0]      status_cnt;
    logic            unused_wdata;

    assign unused_wdata = ^bus.writedata[31:16];

    always_comb begin
        not_empty  = (count_q != '0);
        full       = (count_q == CntW'(Depth));
        rd_ok      = bus.read & ~bus.write;
        pop        = rd_ok & (bus.address == AddrData) & not_empty;
        push_req   = rx_done_i & ~rx_done_q & ctrl_q[0];
        // A full FIFO still accepts the byte when a pop frees a slot on the same edge.
        push       = push_q & (~full | pop);
        status_cnt = 8'(count_q);

        wptr_d    = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d    = pop  ? rptr_q + PtrW'(1) : rptr_q;
        count_d   = count_q;
        if (push && !pop) count_d = count_q + CntW'(1);
        if (pop && !push) count_d = count_q - CntW'(1);

        overrun_d = overrun_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        if (bus.write) begin
            unique case (bus.address)
                AddrStatus: if (bus.writedata[2]) overrun_d = 1'b0;
                AddrCtrl:   ctrl_d = bus.writedata[1:0];
                AddrDiv:    div_d  = (bus.writedata[15:0] == '0) ? 16'd1 : bus.writedata[15:0];
                default:    ;
            endcase
        end
        // Set wins over a simultaneous software clear.
        if (push_q && full && !pop) overrun_d = 1'b1;

        readdata_d = readdata_q;
        if (bus.read) begin
            readdata_d = '0;
            if (rd_ok) begin
                unique case (bus.address)
                    AddrData:   if (not_empty) readdata_d = {23'b0, 1'b1, mem[rptr_q]};
                    AddrStatus: readdata_d = {16'b0, status_cnt, 5'b0, overrun_q, full, not_empty};
                    AddrCtrl:   readdata_d = {30'b0, ctrl_q};
                    AddrDiv:    readdata_d = {16'b0, div_q};
                    default:    ;
                endcase
            end
        end

        irq_d = ctrl_q[1] & (not_empty | overrun_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_done_q   <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            ctrl_q      <= '0;
            div_q       <= DivReset;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            rx_done_q   <= rx_done_i;
            push_q      <= push_req;
            push_byte_q <= rx_data_i;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            ctrl_q      <= ctrl_d;
            div_q       <= div_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= push_byte_q;
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
    assign rx_enable_o  = ctrl_q[0];
    assign baud_div_o   = div_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: reads queue expected values, a negedge monitor checks them.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_enable;
    logic [15:0] baud_div;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(
        .Depth    (8),
        .DivReset (16'd434)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .bus         (bus),
        .rx_data_i   (rx_data),
        .rx_done_i   (rx_done),
        .rx_enable_o (rx_enable),
        .baud_div_o  (baud_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: readdata for a read sampled at edge k is checked in the following cycle.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", bus.readdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, bus.readdata, e.exp);
            end
        end
        rd_pend = bus.read;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        bus.address = addr;
        bus.read    = 1'b1;
        cyc();
        bus.read    = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        cyc();
        bus.write     = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) cyc();
        rx_done = 1'b0;
        cyc();
    endtask

    initial begin
        reset         = 1'b1;
        rx_data       = '0;
        rx_done       = 1'b0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        repeat (2) cyc();
        reset = 1'b0;

        // 1. Reset values and configuration
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        check("rst_rx_enable", {31'b0, rx_enable}, 32'h0);
        check("rst_baud_div", {16'b0, baud_div}, 32'd434);
        bus_read(2'd0, 32'h0, "rst_data");
        bus_read(2'd1, 32'h0, "rst_status");
        bus_read(2'd2, 32'h0, "rst_ctrl");
        bus_read(2'd3, 32'd434, "rst_divisor");
        bus_write(2'd2, 32'h3);
        check("ctrl_rx_enable", {31'b0, rx_enable}, 32'h1);
        bus_write(2'd3, 32'h0);
        check("div_zero_as_one", {16'b0, baud_div}, 32'h1);
        bus_read(2'd3, 32'h1, "div_readback_one");
        bus_write(2'd3, 32'h1234_5678);
        check("div_low_half", {16'b0, baud_div}, 32'h5678);
        bus_read(2'd2, 32'h3, "ctrl_readback");

        // 2. Basic capture
        bus_write(2'd2, 32'h1);
        rx_byte(8'hA5, 1);
        bus_read(2'd1, 32'h0101, "cap_status");
        bus.writedata = 32'hFFFF_FFFF;
        bus.write     = 1'b1;
        bus_read(2'd0, 32'h0, "rd_wr_collision");
        bus.write     = 1'b0;
        bus_read(2'd0, 32'h1A5, "cap_data");
        bus_read(2'd0, 32'h0, "empty_data");
        bus_read(2'd1, 32'h0, "empty_status");

        // 3. Overrun and clear
        for (int i = 0; i < 9; i++) rx_byte(8'(i), 1);
        bus_read(2'd1, 32'h0807, "ovr_status");
        for (int i = 0; i < 8; i++) bus_read(2'd0, 32'h100 | i, "ovr_data");
        bus_read(2'd1, 32'h0004, "ovr_sticky");
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, 32'h0, "ovr_cleared");

        // 4. Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i), 1);
        bus_read(2'd1, 32'h0803, "fill_status");
        rx_data = 8'h55;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        bus_read(2'd0, 32'h110, "simul_pop");
        bus_read(2'd1, 32'h0803, "simul_status");
        for (int i = 1; i < 8; i++) bus_read(2'd0, 32'h110 | i, "simul_data");
        bus_read(2'd0, 32'h155, "simul_last");
        bus_read(2'd1, 32'h0, "simul_empty");

        // 5. Enable gating and interrupt timing
        bus_write(2'd2, 32'h0);
        rx_byte(8'h77, 1);
        bus_read(2'd1, 32'h0, "disabled_status");
        check("disabled_irq", {31'b0, bus.irq}, 32'h0);
        bus_write(2'd2, 32'h3);
        rx_data = 8'h99;
        rx_done = 1'b1;
        cyc();
        check("irq_n1", {31'b0, bus.irq}, 32'h0);
        cyc();
        check("irq_n2", {31'b0, bus.irq}, 32'h0);
        cyc();
        check("irq_n3", {31'b0, bus.irq}, 32'h1);
        repeat (2) cyc();
        rx_done = 1'b0;
        cyc();
        bus_read(2'd1, 32'h0101, "held_status");
        bus_read(2'd0, 32'h199, "held_data");
        cyc();
        check("irq_after_pop", {31'b0, bus.irq}, 32'h0);

        // 6. Reset mid-operation
        for (int i = 0; i < 3; i++) rx_byte(8'hC0 + 8'(i), 1);
        cyc();
        check("irq_before_reset", {31'b0, bus.irq}, 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
        check("mid_rst_rx_enable", {31'b0, rx_enable}, 32'h0);
        check("mid_rst_baud_div", {16'b0, baud_div}, 32'd434);
        bus_read(2'd1, 32'h0, "mid_rst_status");
        bus_read(2'd0, 32'h0, "mid_rst_data");

        repeat (3) cyc();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending reads, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
